// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-side constants and capture FSM state encodings.
package uart_rx_fifo_pkg;

    localparam int unsigned DATA_W        = 8;
    localparam int unsigned DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        RXF_IDLE     = 2'd0,
        RXF_CAPTURE  = 2'd1,
        RXF_ACK      = 2'd2,
        RXF_WAIT_CLR = 2'd3
    } rxf_state_e;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a pop frees space for a same-cycle push.
module uart_rx_fifo_sync_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic [AW:0]   count_nxt_c,
    output logic          push_ok_c
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_ok_c;

    // Pop is evaluated first so a full FIFO can accept a coincident push.
    always_comb begin
        pop_ok_c    = pop && !empty;
        push_ok_c   = push && (!full || pop_ok_c);
        count_nxt_c = count;
        if (push_ok_c && !pop_ok_c) begin
            count_nxt_c = count + (AW+1)'(1);
        end else if (!push_ok_c && pop_ok_c) begin
            count_nxt_c = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt_c;
            empty <= (count_nxt_c == '0);
            full  <= (count_nxt_c == (AW+1)'(DEPTH));
        end
    end

    // Storage is not reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-byte buffer: synchronizes rs, captures and acknowledges each byte,
// queues it for the CPU, and reports threshold/overrun interrupts.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned AW     = 4,
    parameter int unsigned THRESH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_rs,
    output logic              rx_over_read,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       count,
    output logic              overrun,
    input  logic              clr_overrun,
    output logic              irq
);

    rxf_state_e  state;
    rxf_state_e  state_nxt;
    logic        rs_meta;
    logic        rs_s;
    logic        fifo_push_c;
    logic        push_ok_c;
    logic [AW:0] count_nxt_c;
    logic        over_read_nxt_c;
    logic        drop_c;
    logic        overrun_nxt_c;
    logic        irq_nxt_c;

    // rs comes from a derived-clock flop, so resynchronize before use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_meta <= 1'b0;
            rs_s    <= 1'b0;
        end else begin
            rs_meta <= rx_rs;
            rs_s    <= rs_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RXF_IDLE;
            rx_over_read <= 1'b0;
            overrun      <= 1'b0;
            irq          <= 1'b0;
        end else begin
            state        <= state_nxt;
            rx_over_read <= over_read_nxt_c;
            overrun      <= overrun_nxt_c;
            irq          <= irq_nxt_c;
        end
    end

    // WAIT_CLR holds off until rs drops so one byte is never captured twice.
    always_comb begin
        state_nxt       = state;
        fifo_push_c     = 1'b0;
        over_read_nxt_c = 1'b0;
        case (state)
            RXF_IDLE: begin
                if (rs_s) begin
                    state_nxt = RXF_CAPTURE;
                end
            end
            RXF_CAPTURE: begin
                fifo_push_c = 1'b1;
                state_nxt   = RXF_ACK;
            end
            RXF_ACK: begin
                state_nxt = RXF_WAIT_CLR;
            end
            RXF_WAIT_CLR: begin
                if (!rs_s) begin
                    state_nxt = RXF_IDLE;
                end
            end
            default: begin
                state_nxt = RXF_IDLE;
            end
        endcase
        over_read_nxt_c = (state_nxt == RXF_ACK);
    end

    // A drop sets overrun even when a clear arrives in the same cycle.
    always_comb begin
        drop_c        = fifo_push_c && !push_ok_c;
        overrun_nxt_c = drop_c || (overrun && !clr_overrun);
        irq_nxt_c     = (count_nxt_c >= (AW+1)'(THRESH)) || overrun_nxt_c;
    end

    uart_rx_fifo_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (fifo_push_c),
        .pop         (rd_en),
        .din         (rx_data),
        .dout        (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .count_nxt_c (count_nxt_c),
        .push_ok_c   (push_ok_c)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed/randomized bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AW     = 4;
    localparam int unsigned THRESH = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_rs;
    logic        rx_over_read;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        empty;
    logic        full;
    logic [AW:0] count;
    logic        overrun;
    logic        clr_overrun;
    logic        irq;

    int tests = 0;
    int fails = 0;
    int ack_cnt = 0;

    logic [7:0] q[$];
    bit         ovr;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_over_read === 1'b1) ack_cnt++;
    end

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .THRESH(THRESH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_rs        (rx_rs),
        .rx_over_read (rx_over_read),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun),
        .irq          (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        chk({tag, ".overrun"}, 32'(overrun), 32'(ovr));
        chk({tag, ".irq"}, 32'(irq), 32'((q.size() >= THRESH) || ovr));
        if (q.size() > 0) chk({tag, ".rd_data"}, 32'(rd_data), 32'(q[0]));
    endtask

    // Receive-unit behaviour: raise rs, hold it until over_read (plus hold cycles), then drop it.
    task automatic deliver(input logic [7:0] d, input bit pop_cap, input bit clr_cap, input int hold);
        int n;
        bit seen;
        int base;
        base    = ack_cnt;
        rx_data = d;
        rx_rs   = 1'b1;
        n       = 0;
        seen    = 1'b0;
        while (!seen && n < 20) begin
            if (n == 3) begin
                if (pop_cap) begin
                    if (q.size() > 0) chk("cap_pop.rd_data", 32'(rd_data), 32'(q[0]));
                    rd_en = 1'b1;
                end
                if (clr_cap) clr_overrun = 1'b1;
            end
            step();
            n++;
            rd_en       = 1'b0;
            clr_overrun = 1'b0;
            if (rx_over_read === 1'b1) seen = 1'b1;
        end
        chk("ack_latency", 32'(n), 32'd4);
        if (pop_cap && q.size() > 0) void'(q.pop_front());
        if (clr_cap) ovr = 1'b0;
        if (q.size() < DEPTH) q.push_back(d);
        else ovr = 1'b1;
        repeat (hold) step();
        rx_rs = 1'b0;
        repeat (4) step();
        chk("ack_pulses", 32'(ack_cnt - base), 32'd1);
        check_state("deliver");
    endtask

    task automatic pop(input string tag);
        if (q.size() > 0) chk({tag, ".head"}, 32'(rd_data), 32'(q[0]));
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        check_state(tag);
    endtask

    initial begin
        rst_n       = 1'b0;
        rx_data     = 8'h00;
        rx_rs       = 1'b0;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
        ovr         = 1'b0;
        repeat (3) step();
        chk("rst.over_read", 32'(rx_over_read), 32'd0);
        check_state("rst");
        rst_n = 1'b1;
        step();

        // Single byte, then pop back to empty.
        deliver(8'h5A, 1'b0, 1'b0, 0);
        pop("single_pop");

        // Pop while empty is ignored; held rs yields one capture.
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_state("empty_pop");
        deliver(8'($urandom), 1'b0, 1'b0, 10);
        pop("hold_pop");

        // Fill with 0x00..0x0F and drain in order.
        for (int i = 0; i < 16; i++) deliver(8'(i), 1'b0, 1'b0, 0);
        for (int i = 0; i < 16; i++) pop("fill_pop");

        // Pointer wrap.
        for (int i = 0; i < 3; i++) begin
            deliver(8'($urandom), 1'b0, 1'b0, $urandom_range(0, 2));
            pop("wrap_pop");
        end

        // Overrun while full; clear coinciding with a drop keeps it set.
        for (int i = 0; i < 16; i++) deliver(8'($urandom), 1'b0, 1'b0, 0);
        deliver(8'hEE, 1'b0, 1'b0, 0);
        deliver(8'($urandom), 1'b0, 1'b1, 0);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        ovr = 1'b0;
        check_state("clr");

        // Push and pop in the CAPTURE cycle while full.
        deliver(8'($urandom), 1'b1, 1'b0, 0);
        while (q.size() > 0) pop("drain");

        // Reset asserted during ACK.
        deliver(8'($urandom), 1'b0, 1'b0, 0);
        rx_data = 8'($urandom);
        rx_rs   = 1'b1;
        repeat (4) step();
        chk("pre_rst.over_read", 32'(rx_over_read), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.over_read", 32'(rx_over_read), 32'd0);
        chk("mid_rst.count", 32'(count), 32'd0);
        chk("mid_rst.empty", 32'(empty), 32'd1);
        rx_rs = 1'b0;
        q.delete();
        ovr = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check_state("post_rst");
        deliver(8'($urandom), 1'b0, 1'b0, 0);
        pop("post_rst_pop");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Downstream stage of the UART receive unit. Consumes its parallel byte (d_out) and receive-status flag (rs).
- Acknowledges each byte with a one-cycle over_read pulse, which clears rs.
- Buffers received bytes in a DEPTH-entry FIFO so the CPU bus interface can drain them in bursts, without losing data between polls.
- Raises a level interrupt on a fill threshold and flags overrun.

Parameters:
- DEPTH, 16, number of byte entries; power of two, ≥ 2
- AW, 4, pointer width; log2(DEPTH)
- THRESH, 1, irq asserts when count ≥ THRESH; range 1..DEPTH

Ports:
- clk  in  1  system clock; same clock as the receive unit
- rst_n  in  1  asynchronous, active-low reset
- rx_data  in  8  byte from the receive unit (d_out)
- rx_rs  in  1  receive status from the receive unit (rs); high = byte available
- rx_over_read  out  1  one-cycle pulse to the receive unit's over_read; clears rs
- rd_en  in  1  CPU pop strobe, one cycle per byte
- rd_data  out  8  head-of-FIFO byte (first-word fall-through); valid when !empty
- empty  out  1  FIFO holds 0 bytes
- full  out  1  FIFO holds DEPTH bytes
- count  out  AW+1  current occupancy, 0..DEPTH
- overrun  out  1  sticky: a byte arrived while full and was dropped
- clr_overrun  in  1  synchronous clear of overrun
- irq  out  1  level interrupt: count ≥ THRESH, or overrun set

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overrun=0, rx_over_read=0, irq=0, capture FSM=IDLE, sync flops=0. Memory contents are not reset. rd_data is don't-care while empty.
- rx_rs passes through a 2-flop synchronizer to rs_s, because rs is produced by a derived-clock flop. All further logic uses rs_s.
- Capture FSM, 2-bit state:
  - IDLE: if rs_s=1, go to CAPTURE.
  - CAPTURE, one cycle:
    - If !full (evaluated after any same-cycle pop), write rx_data to mem[wr_ptr] and increment wr_ptr modulo DEPTH.
    - Else drop the byte and set overrun=1.
    - Go to ACK.
  - ACK, one cycle: rx_over_read=1. Go to WAIT_CLR.
  - WAIT_CLR: stay until rs_s=0, then go to IDLE. This prevents double capture of one byte.
- Latency:
  - rx_rs rise → write into memory: 3 clk (2 sync + CAPTURE).
  - rx_rs rise → rx_over_read pulse: 4 clk.
  - Write → empty deasserts: next cycle.
- rx_data is sampled only in CAPTURE. It is stable there because the receive unit does not shift a new byte until ≥1 bit time after its stop bit.
- Pop: if rd_en=1 and !empty, increment rd_ptr modulo DEPTH. rd_data = mem[rd_ptr] combinationally. rd_en while empty is ignored: no pointer change, no error flag.
- Push and pop in the same cycle:
  - Both occur and count is unchanged.
  - When full, the pop frees space first, so the push succeeds and no overrun is raised.
  - When empty, the pop is ignored and the push succeeds.
- count updates +1 on push only, −1 on pop only. full = (count==DEPTH), empty = (count==0), both derived from count.
- Pointers wrap from DEPTH−1 to 0 with no special handling.
- overrun: set on a dropped byte, cleared by clr_overrun. If set and clear coincide, set wins. Once set, it holds until cleared.
- irq is registered: irq <= (count_next ≥ THRESH) | overrun_next. It falls the cycle after the pop that takes count below THRESH, if overrun=0.
- Reset asserted mid-frame or mid-handshake: the FSM returns to IDLE immediately. After release, if rs is still high, one capture occurs. The receive unit shares the reset, so rs is normally already low.

Decomposition:
- Shared header, head_uart: UART constants plus the RXF FSM state encodings (RXF_IDLE=0, RXF_CAPTURE=1, RXF_ACK=2, RXF_WAIT_CLR=3) and a default FIFO depth macro.
- One sub-module: sync_fifo, holding the memory, pointers, count, full and empty, with ports push/pop/din/dout. It is reusable for the transmit side.
- The top level holds the synchronizer, capture FSM, overrun and irq.

Test Plan:
- Single byte: rx_data=0x5A with rx_rs pulsed high until rx_over_read → over_read seen exactly once, 4 clk after the rs rise; empty=0, count=1, rd_data=0x5A, irq=1; rd_en → empty=1, irq=0.
- Fill: 16 bytes 0x00..0x0F → full=1, count=16, overrun=0. Pop all → bytes emerge 0x00..0x0F in order; pointer wrap checked by a further 3 push/pop cycles.
- Overrun: while full, deliver 0xEE → over_read still pulses, 0xEE is not stored, overrun=1, irq=1. clr_overrun with a simultaneous new drop → overrun stays 1.
- Simultaneous push and pop when full: CAPTURE coincides with rd_en → count stays 16, overrun=0, new byte appears at the tail.
- rd_en while empty: count stays 0, pointers unchanged. Holding rx_rs high for 10 clk without clearing produces only one capture.
- Reset mid-handshake: drop rst_n during ACK → rx_over_read=0 and count=0 asynchronously; FSM returns to IDLE.
